// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one asynchronous SRAM bus between a CPU port (0) and a
// DMA/loader port (1). Each access runs SETUP -> optional WAIT -> STROBE -> DONE so
// that address and data are stable on both sides of the oe/we strobe.
// All outputs are registered. mem_oe and mem_we are active-low.
//
// Optional build macro: ARB_FIXED_PRIORITY_EN
//   defined   : port 0 always wins contention (port 1 may starve)
//   undefined : round-robin between the two ports
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | bus parked, waiting for a request
// SETUP   | address (and write data) driven; oe low for reads
// WAIT    | WAIT_STATES extra cycles of address/data settle time
// STROBE  | we low for writes; read data captured at end of cycle
// DONE    | strobe released, write data held, ack pulsed to granted port
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_d_out,
    output logic                  mem_d_oe,
    input  logic [DATA_WIDTH-1:0] mem_d_in,
    output logic                  mem_oe,
    output logic                  mem_we
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Down-counter preload: WAIT is left when the count reaches zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]            state;
    logic                  cur_port;
    logic                  cur_wr;
    logic [3:0]            wait_cnt;
    logic                  grant_port;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifndef ARB_FIXED_PRIORITY_EN
    logic last_grant;

    // Round-robin history: remembers which port won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (state == S_IDLE && (p0_req || p1_req))
            last_grant <= grant_port;
    end
`endif

    // Pick the winning port and mux its access attributes.
    always_comb begin
        grant_port = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
        grant_port = ~p0_req;
`else
        if (p0_req && p1_req)
            grant_port = ~last_grant;
        else
            grant_port = ~p0_req;
`endif
        sel_wr    = grant_port ? p1_wr    : p0_wr;
        sel_addr  = grant_port ? p1_addr  : p0_addr;
        sel_wdata = grant_port ? p1_wdata : p0_wdata;
    end

    // Access sequencer; bus strobes are set on entry to each state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_port  <= 1'b0;
            cur_wr    <= 1'b0;
            wait_cnt  <= 4'd0;
            mem_a     <= '0;
            mem_d_out <= '0;
            mem_d_oe  <= 1'b0;
            mem_oe    <= 1'b1;
            mem_we    <= 1'b1;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        cur_port <= grant_port;
                        cur_wr   <= sel_wr;
                        mem_a    <= sel_addr;
                        if (sel_wr) begin
                            mem_d_out <= sel_wdata;
                            mem_d_oe  <= 1'b1;
                        end else begin
                            mem_oe <= 1'b0;
                        end
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (WAIT_STATES == 0) begin
                        if (cur_wr)
                            mem_we <= 1'b0;
                        state <= S_STROBE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (cur_wr)
                            mem_we <= 1'b0;
                        state <= S_STROBE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cur_wr) begin
                        mem_we <= 1'b1;
                    end else begin
                        mem_oe <= 1'b1;
                        if (cur_port)
                            p1_rdata <= mem_d_in;
                        else
                            p0_rdata <= mem_d_in;
                    end
                    if (cur_port)
                        p1_ack <= 1'b1;
                    else
                        p0_ack <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // Address and write data stay put for hold; only the driver is released.
                    mem_d_oe <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with no wait states (directed + random
// traffic against a reference model) and one with two wait states (latency, reset abort).
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk;
    logic rst, w_rst;

    logic          p0_req, p0_wr, p1_req, p1_wr, p0_ack, p1_ack;
    logic [AW-1:0] p0_addr, p1_addr, mem_a;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_d_out, mem_d_in;
    logic          mem_d_oe, mem_oe, mem_we;

    logic          w_p0_req, w_p0_wr, w_p1_req, w_p1_wr, w_p0_ack, w_p1_ack;
    logic [AW-1:0] w_p0_addr, w_p1_addr, w_mem_a;
    logic [DW-1:0] w_p0_wdata, w_p1_wdata, w_p0_rdata, w_p1_rdata, w_mem_d_out, w_mem_d_in;
    logic          w_mem_d_oe, w_mem_oe, w_mem_we;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_a(mem_a), .mem_d_out(mem_d_out), .mem_d_oe(mem_d_oe), .mem_d_in(mem_d_in),
        .mem_oe(mem_oe), .mem_we(mem_we)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) dut_w (
        .clk(clk), .rst(w_rst),
        .p0_req(w_p0_req), .p0_wr(w_p0_wr), .p0_addr(w_p0_addr), .p0_wdata(w_p0_wdata),
        .p0_ack(w_p0_ack), .p0_rdata(w_p0_rdata),
        .p1_req(w_p1_req), .p1_wr(w_p1_wr), .p1_addr(w_p1_addr), .p1_wdata(w_p1_wdata),
        .p1_ack(w_p1_ack), .p1_rdata(w_p1_rdata),
        .mem_a(w_mem_a), .mem_d_out(w_mem_d_out), .mem_d_oe(w_mem_d_oe), .mem_d_in(w_mem_d_in),
        .mem_oe(w_mem_oe), .mem_we(w_mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background contents of an unwritten SRAM location.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // SRAM models: written locations tracked by flag, others return the background pattern.
    bit [7:0] ram    [65536];
    bit       ram_wf [65536];
    bit [7:0] ramw   [65536];
    bit       ramw_wf[65536];

    assign mem_d_in   = !mem_oe   ? (ram_wf[mem_a]    ? ram[mem_a]    : pat(mem_a))   : 8'hEE;
    assign w_mem_d_in = !w_mem_oe ? (ramw_wf[w_mem_a] ? ramw[w_mem_a] : pat(w_mem_a)) : 8'hEE;

    always @(posedge clk) begin
        if (!mem_we) begin
            ram[mem_a]    <= mem_d_out;
            ram_wf[mem_a] <= 1'b1;
        end
        if (!w_mem_we) begin
            ramw[w_mem_a]    <= w_mem_d_out;
            ramw_wf[w_mem_a] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: memory contents and arbitration rule.
    logic [7:0] mdl_mem [int];
    int         mdl_last = 1;

    function automatic logic [7:0] mdl_rd(input logic [15:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : pat(a);
    endfunction

    function automatic int winner(input logic [1:0] m, input int last);
`ifdef ARB_FIXED_PRIORITY_EN
        return m[0] ? 0 : 1;
`else
        if (m == 2'b11) return 1 - last;
        return m[0] ? 0 : 1;
`endif
    endfunction

    // Bus protocol monitor.
    logic          prev_we_low = 1'b0;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;
    always @(negedge clk) begin
        if (!rst) begin
            check("oe_we_overlap", 32'(!mem_oe && !mem_we), 0);
            check("doe_oe_conflict", 32'(mem_d_oe && !mem_oe), 0);
            if (prev_we_low) begin
                check("we_pulse_width", 32'(mem_we), 1);
                check("hold_addr", 32'(mem_a), 32'(prev_a));
                check("hold_data", 32'(mem_d_out), 32'(prev_d));
                check("hold_doe", 32'(mem_d_oe), 1);
            end
            prev_we_low = !mem_we;
            prev_a      = mem_a;
            prev_d      = mem_d_out;
        end
        if (!w_rst) check("w_oe_we_overlap", 32'(!w_mem_oe && !w_mem_we), 0);
    end

    logic [AW-1:0] we_a;
    logic [DW-1:0] we_d;

    task automatic set_port(input int port, input logic rq, input logic wr,
                            input logic [15:0] addr, input logic [7:0] wd);
        if (port == 0) begin
            p0_req = rq; p0_wr = wr; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = rq; p1_wr = wr; p1_addr = addr; p1_wdata = wd;
        end
    endtask

    // n counts rising edges from the request-sampling edge; the ack cycle is n = 3 + wait states.
    task automatic wait_ack(output logic [1:0] acks, output int n, output int we_low, output int oe_low);
        n = 0; we_low = 0; oe_low = 0; acks = 2'b00;
        while (acks == 2'b00 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (!mem_we) begin
                we_low++;
                we_a = mem_a;
                we_d = mem_d_out;
            end
            if (!mem_oe) oe_low++;
            acks = {p1_ack, p0_ack};
        end
        check("ack_seen", 32'(acks != 2'b00), 1);
    endtask

    task automatic access(input int port, input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                          output logic [1:0] acks, output int n, output int we_low, output int oe_low);
        @(posedge clk); #1;
        set_port(port, 1'b1, wr, addr, wd);
        wait_ack(acks, n, we_low, oe_low);
        set_port(port, 1'b0, wr, addr, wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  acks;
        int          n, we_low, oe_low, first, other, ack_cnt;
        logic [1:0]  mask;
        logic        r_wr   [2];
        logic [15:0] r_addr [2];
        logic [7:0]  r_wd   [2];

        rst = 1'b1; w_rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_port(1, 1'b0, 1'b0, 16'h0, 8'h0);
        w_p0_req = 0; w_p0_wr = 0; w_p0_addr = '0; w_p0_wdata = '0;
        w_p1_req = 0; w_p1_wr = 0; w_p1_addr = '0; w_p1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_oe", 32'(mem_oe), 1);
        check("rst_mem_we", 32'(mem_we), 1);
        check("rst_mem_d_oe", 32'(mem_d_oe), 0);
        check("rst_acks", 32'({p1_ack, p0_ack}), 0);
        check("rst_mem_a", 32'(mem_a), 0);
        check("rst_rdata", 32'({p1_rdata, p0_rdata}), 0);
        check("rst_w_mem_oe", 32'(w_mem_oe), 1);
        rst = 1'b0; w_rst = 1'b0;

        // p0 write 0xA5 to 0x0003
        access(0, 1'b1, 16'h0003, 8'hA5, acks, n, we_low, oe_low);
        mdl_mem[3] = 8'hA5; mdl_last = 0;
        check("wr_latency", 32'(n), 3);
        check("wr_ack_port", 32'(acks), 32'b01);
        check("wr_we_low_cycles", 32'(we_low), 1);
        check("wr_strobe_addr", 32'(we_a), 32'h0003);
        check("wr_strobe_data", 32'(we_d), 32'hA5);
        check("wr_ram3", 32'(ram[3]), 32'hA5);

        // p1 reads it back
        access(1, 1'b0, 16'h0003, 8'h00, acks, n, we_low, oe_low);
        mdl_last = 1;
        check("rd_latency", 32'(n), 3);
        check("rd_ack_port", 32'(acks), 32'b10);
        check("rd_oe_low_cycles", 32'(oe_low), 2);
        check("rd_p1_rdata", 32'(p1_rdata), 32'(mdl_rd(16'h0003)));

        // Continuous contention: p0 writes 0x20, p1 reads 0x21
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 16'h0020, 8'h11);
        set_port(1, 1'b1, 1'b0, 16'h0021, 8'h00);
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wait_ack(acks, n, we_low, oe_low);
            first = winner(2'b11, mdl_last);
            mdl_last = first;
            check("cont_grant", 32'(acks), 32'(1 << first));
            check("cont_period", 32'(n), (i == 0) ? 3 : 4);
            if (first == 0) mdl_mem[16'h20] = 8'h11;
            else check("cont_p1_rdata", 32'(p1_rdata), 32'(mdl_rd(16'h0021)));
            if (acks[1]) ack_cnt++;
        end
        set_port(0, 1'b0, 1'b1, 16'h0020, 8'h11);
        set_port(1, 1'b0, 1'b0, 16'h0021, 8'h00);
`ifdef ARB_FIXED_PRIORITY_EN
        check("cont_p1_acks", 32'(ack_cnt), 0);
`else
        check("cont_p1_acks", 32'(ack_cnt), 4);
`endif
        check("cont_ram20", 32'(ram[16'h20]), 32'h11);

        // Random traffic against the reference model
        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1;
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                r_wr[p]   = 1'($urandom_range(0, 1));
                r_addr[p] = 16'h0080 + 16'($urandom_range(0, 7));
                r_wd[p]   = 8'($urandom);
                set_port(p, mask[p], r_wr[p], r_addr[p], r_wd[p]);
            end
            first = winner(mask, mdl_last);
            for (int k = 0; k < 2; k++) begin
                if (k == 1 && mask != 2'b11) break;
                wait_ack(acks, n, we_low, oe_low);
                check("rnd_grant", 32'(acks), 32'(1 << first));
                check("rnd_latency", 32'(n), (k == 0) ? 3 : 4);
                if (r_wr[first]) begin
                    mdl_mem[int'(r_addr[first])] = r_wd[first];
                    check("rnd_we_low", 32'(we_low), 1);
                    check("rnd_we_addr", 32'(we_a), 32'(r_addr[first]));
                    check("rnd_we_data", 32'(we_d), 32'(r_wd[first]));
                end else begin
                    check("rnd_rdata", 32'(first ? p1_rdata : p0_rdata), 32'(mdl_rd(r_addr[first])));
                end
                mdl_last = first;
                set_port(first, 1'b0, r_wr[first], r_addr[first], r_wd[first]);
                other = 1 - first;
                first = other;
            end
        end
        for (int a = 16'h80; a < 16'h88; a++)
            check("rnd_ram_final", 32'(ram_wf[a] ? ram[a] : pat(16'(a))), 32'(mdl_rd(16'(a))));

        // Two wait states: read latency and strobe length
        @(posedge clk); #1;
        w_p0_req = 1; w_p0_wr = 0; w_p0_addr = 16'h0010;
        n = 0; oe_low = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!w_mem_oe) oe_low++;
        end while (!w_p0_ack && n < 30);
        w_p0_req = 0;
        check("w2_rd_latency", 32'(n), 5);
        check("w2_rd_oe_low", 32'(oe_low), 4);
        check("w2_rd_rdata", 32'(w_p0_rdata), 32'(pat(16'h0010)));

        // Reset during WAIT of a write aborts it
        @(posedge clk); #1;
        w_p0_req = 1; w_p0_wr = 1; w_p0_addr = 16'h0040; w_p0_wdata = 8'h3C;
        @(posedge clk); #1;
        check("w2_setup_doe", 32'(w_mem_d_oe), 1);
        @(posedge clk); #1;
        w_rst = 1'b1; w_p0_req = 0;
        @(posedge clk); #1;
        check("abort_we", 32'(w_mem_we), 1);
        check("abort_doe", 32'(w_mem_d_oe), 0);
        check("abort_ack", 32'(w_p0_ack), 0);
        @(posedge clk); #1;
        w_rst = 1'b0;
        ack_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (w_p0_ack || w_p1_ack) ack_cnt++;
        end
        check("abort_no_ack", 32'(ack_cnt), 0);
        check("abort_ram", 32'(ramw_wf[16'h40] ? ramw[16'h40] : pat(16'h0040)), 32'(pat(16'h0040)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
